nanorv32_lsu: RTL and testbench

//  Load/store unit between the nanorv32 execute stage and the data memory port (cpu_datamem_*).

---
 rtl/nanorv32_lsu.sv | 182 ++++++++++++++++++
 tb/tb_nanorv32_lsu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_lsu.sv
// nanorv32 load/store unit: sits between the execute stage and the data
// memory port. One access in flight; byte/half/word lane steering, load
// extension, misalignment trap and a bus wait-state timeout.

// Per-byte-lane store steering: lane enable and the store byte for this lane.
module nanorv32_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  output logic        sel,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = LANE[1:0];

  // Byte replicates d[7:0], half replicates d[15:0], word passes straight.
  always_comb begin
    sel   = 1'b0;
    wbyte = wdata_in[7:0];
    case (size)
      2'd0: begin
        sel   = (off == L);
        wbyte = wdata_in[7:0];
      end
      2'd1: begin
        sel   = (off[1] == L[1]);
        wbyte = L[0] ? wdata_in[15:8] : wdata_in[7:0];
      end
      default: begin
        sel   = 1'b1;
        wbyte = wdata_in[8*LANE +: 8];
      end
    endcase
  end
endmodule

module nanorv32_lsu #(
  parameter int NRV32_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int TIMEOUT_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [NRV32_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_err,
  output logic [NRV32_ADDR_WIDTH-1:0] cpu_datamem_addr,
  output logic [31:0]                 cpu_datamem_wdata,
  output logic [3:0]                  cpu_datamem_bytesel,
  output logic                        cpu_datamem_valid,
  output logic                        cpu_datamem_we,
  input  logic [31:0]                 datamem_cpu_rdata,
  input  logic                        datamem_cpu_ready
);
  localparam int NUM_LANES = 4;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Access attributes kept for load extraction once the bus answers.
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } acc_t;

  state_t state, state_nxt;
  acc_t   acc_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

  logic accept, misal, bus_done, tmo_hit;
  logic [NUM_LANES-1:0]      lane_sel;
  logic [NUM_LANES-1:0][7:0] lane_wdata;
  logic [31:0] lane_shift, load_data;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;

  assign misal = (req_size == 2'd3) ||
                 (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  assign bus_done = (state == ACCESS) && datamem_cpu_ready;
  // A ready on the final timeout edge wins, hence the !ready term.
  assign tmo_hit  = TMO_EN && (state == ACCESS) && !datamem_cpu_ready &&
                    (tmo_cnt == TMO_LAST);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    nanorv32_lsu_lane #(.LANE(i)) u_lane (
      .size     (req_size),
      .off      (req_addr[1:0]),
      .wdata_in (req_wdata),
      .sel      (lane_sel[i]),
      .wbyte    (lane_wdata[i])
    );
  end

  // Word loads always carry offset 0, so the shifted value is the word itself.
  assign lane_shift = datamem_cpu_rdata >> {acc_q.off, 3'b000};

  // Sign- or zero-extend the selected lane.
  always_comb begin
    load_data = lane_shift;
    case (acc_q.size)
      2'd0:    load_data = {{24{~acc_q.uns & lane_shift[7]}},  lane_shift[7:0]};
      2'd1:    load_data = {{16{~acc_q.uns & lane_shift[15]}}, lane_shift[15:0]};
      default: load_data = lane_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: misaligned requests skip the bus entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misal ? RESP : ACCESS;
      ACCESS:  if (bus_done || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter, restarted by every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       tmo_cnt <= '0;
    else if (accept)                                  tmo_cnt <= '0;
    else if (state == ACCESS && !datamem_cpu_ready)   tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
  end

  // Bus request registers: loaded on a legal accept, held through ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_datamem_valid   <= 1'b0;
      cpu_datamem_addr    <= '0;
      cpu_datamem_wdata   <= '0;
      cpu_datamem_bytesel <= '0;
      cpu_datamem_we      <= 1'b0;
      acc_q               <= '0;
    end else if (accept && !misal) begin
      cpu_datamem_valid   <= 1'b1;
      cpu_datamem_addr    <= {req_addr[NRV32_ADDR_WIDTH-1:2], 2'b00};
      cpu_datamem_wdata   <= lane_wdata;
      cpu_datamem_bytesel <= lane_sel;
      cpu_datamem_we      <= req_we;
      acc_q               <= '{off: req_addr[1:0], size: req_size, uns: req_unsigned};
    end else if (bus_done || tmo_hit) begin
      cpu_datamem_valid   <= 1'b0;
    end
  end

  // Response payload, held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept && misal) begin
      resp_rdata <= '0;
      resp_err   <= 1'b1;
    end else if (bus_done) begin
      resp_rdata <= cpu_datamem_we ? 32'h0 : load_data;
      resp_err   <= 1'b0;
    end else if (tmo_hit) begin
      resp_rdata <= '0;
      resp_err   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nanorv32_lsu.sv
// Scoreboard bench for nanorv32_lsu with a wait-state bus model.
module tb_nanorv32_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] cpu_datamem_addr, cpu_datamem_wdata;
  logic [3:0]  cpu_datamem_bytesel;
  logic        cpu_datamem_valid, cpu_datamem_we;
  logic [31:0] datamem_cpu_rdata = '0;
  logic        datamem_cpu_ready = 1'b0;

  nanorv32_lsu #(.NRV32_ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .cpu_datamem_addr(cpu_datamem_addr),
    .cpu_datamem_wdata(cpu_datamem_wdata), .cpu_datamem_bytesel(cpu_datamem_bytesel),
    .cpu_datamem_valid(cpu_datamem_valid), .cpu_datamem_we(cpu_datamem_we),
    .datamem_cpu_rdata(datamem_cpu_rdata), .datamem_cpu_ready(datamem_cpu_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, last_lat = -1;
  int vld_cnt = 0, wcnt = 0, waits = 0;
  bit never_ready = 1'b0;
  logic [31:0] mem_word = '0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_we;
  logic [32:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[int'(a)*8 +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: ready after 'waits' stall cycles; noisy ready/rdata while idle.
  always @(negedge clk) begin
    if (!cpu_datamem_valid) begin
      wcnt = 0;
      datamem_cpu_ready = 1'b1;
      datamem_cpu_rdata = 32'hDEAD_BEEF;
    end else begin
      if (wcnt == 0) begin
        cap_addr = cpu_datamem_addr; cap_wdata = cpu_datamem_wdata;
        cap_sel = cpu_datamem_bytesel; cap_we = cpu_datamem_we;
      end else begin
        chk("stable_addr", cpu_datamem_addr, cap_addr);
        chk("stable_wdata", cpu_datamem_wdata, cap_wdata);
        chk("stable_sel", 32'(cpu_datamem_bytesel), 32'(cap_sel));
        chk("stable_we", 32'(cpu_datamem_we), 32'(cap_we));
      end
      vld_cnt++;
      datamem_cpu_ready = !never_ready && (wcnt == waits);
      datamem_cpu_rdata = datamem_cpu_ready ? mem_word : 32'hDEAD_BEEF;
      wcnt++;
    end
  end

  // Response monitor: every resp_valid pulse pops one expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      last_lat = cyc - acc_cyc;
      if (sb_q.size() == 0) chk("spurious_resp", 32'(resp_valid), 32'h0);
      else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e[32:1]);
        chk("resp_err", 32'(resp_err), 32'(e[0]));
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    sb_q.push_back({exp_rd, exp_err});
    vld_cnt = 0; last_lat = -1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin @(negedge clk); #1; end
    chk("resp_seen_pending", 32'(sb_q.size()), 32'h0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_bus_valid", 32'(cpu_datamem_valid), 32'h0);
    chk("rst_bus_addr", cpu_datamem_addr, 32'h0);
    chk("rst_bus_sel", 32'(cpu_datamem_bytesel), 32'h0);
    chk("rst_bus_wdata", cpu_datamem_wdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // lb 0x103, zero wait
    waits = 0; mem_word = 32'h80AB_CD12;
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0);
    wait_resp();
    chk("lb_sel", 32'(cap_sel), 32'h8);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_we", 32'(cap_we), 32'h0);
    chk("lb_vld_cycles", 32'(vld_cnt), 32'h1);
    chk("lb_latency", 32'(last_lat), 32'h1);
    repeat (2) @(negedge clk);
    chk("resp_hold", resp_rdata, 32'hFFFF_FF80);

    // lhu 0x102
    mem_word = 32'h8001_7FFF;
    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h0000_8001, 1'b0);
    wait_resp();
    chk("lhu_sel", 32'(cap_sel), 32'hC);

    // sh 0x102, 3 wait states
    waits = 3;
    issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_BEEF, 32'h0, 1'b0);
    wait_resp();
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_sel", 32'(cap_sel), 32'hC);
    chk("sh_we", 32'(cap_we), 32'h1);
    chk("sh_vld_cycles", 32'(vld_cnt), 32'h4);

    // misaligned / illegal: no bus cycle, response next cycle
    waits = 0;
    issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1);
    wait_resp();
    chk("lw_mis_vld_cycles", 32'(vld_cnt), 32'h0);
    chk("lw_mis_latency", 32'(last_lat), 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1);
    wait_resp();
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h5555_AAAA, 32'h0, 1'b1);
    wait_resp();
    chk("ill_vld_cycles", 32'(vld_cnt), 32'h0);

    // timeout with ready never arriving
    never_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    wait_resp();
    chk("tmo_vld_cycles", 32'(vld_cnt), 32'h4);
    never_ready = 1'b0;

    // ready on the last allowed cycle wins
    waits = 3; mem_word = 32'h1122_3344;
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h1122_3344, 1'b0);
    wait_resp();
    chk("tmo_edge_vld_cycles", 32'(vld_cnt), 32'h4);

    // asynchronous reset during an ACCESS wait
    never_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_bus_valid", 32'(cpu_datamem_valid), 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h1);
    chk("arst_resp_valid", 32'(resp_valid), 32'h0);
    chk("arst_bus_sel", 32'(cpu_datamem_bytesel), 32'h0);
    chk("arst_resp_rdata", resp_rdata, 32'h0);
    sb_q.delete();
    never_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    waits = 1; mem_word = 32'hCAFE_F00D;
    issue(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'hCAFE_F00D, 1'b0);
    wait_resp();
    chk("post_rst_addr", cap_addr, 32'h304);

    // random aligned traffic
    for (int k = 0; k < 10; k++) begin
      logic [1:0] sz; logic [31:0] a, d; logic we, u;
      sz = 2'($urandom_range(0, 2));
      a = $urandom & 32'hFFFF_FFFF;
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      d = $urandom; we = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      mem_word = $urandom; waits = $urandom_range(0, 2);
      issue(we, sz, u, a, d, we ? 32'h0 : model_load(mem_word, a[1:0], sz, u), 1'b0);
      wait_resp();
      chk("rnd_sel", 32'(cap_sel), 32'(model_sel(a[1:0], sz)));
      chk("rnd_addr", cap_addr, {a[31:2], 2'b00});
      if (we) chk("rnd_wdata", cap_wdata, model_wdata(d, sz));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
